// File: rtl/fib_sched_pkg.sv
// Shared types and constants for the Fibonacci request scheduler.
// Any block that talks to the engine or the scheduler FSM imports this package.
package fib_sched_pkg;

    localparam int FIB_IDX_W = 8;
    localparam int FIB_RES_W = 20;
    localparam int FIB_MAX_N = 30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } sched_state_t;

    // Width needed for a counter that runs 0..timeout-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/fib_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after i_ptr,
// wrapping around. Returns a one-hot grant and the encoded index.
module fib_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    int unsigned w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_k = (32'(i_ptr) + i) % NUM_REQ;
            if (!o_any && i_req[w_k]) begin
                o_any        = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = PTR_W'(w_k);
            end
        end
    end

endmodule

// File: rtl/fib_request_scheduler.sv
// Shares one Fibonacci engine between NUM_REQ requesters: round-robin accept,
// start/done handshake with timeout, range check, and per-requester response.
module fib_request_scheduler
    import fib_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int MAX_N   = FIB_MAX_N
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [FIB_IDX_W*NUM_REQ-1:0]   req_number,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [FIB_RES_W-1:0]           rsp_data,
    output logic                           rsp_err,
    output logic                           eng_start,
    output logic [FIB_IDX_W-1:0]           eng_number,
    input  logic                           eng_done,
    input  logic [FIB_RES_W-1:0]           eng_result,
    output logic                           busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    sched_state_t           r_state;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_gnt_idx;
    logic [NUM_REQ-1:0]     r_gnt_oh;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [FIB_RES_W-1:0]   r_rsp_data;
    logic                   r_rsp_err;
    logic                   r_eng_start;
    logic [FIB_IDX_W-1:0]   r_eng_number;
    logic [CNT_W-1:0]       r_cnt;

    logic [NUM_REQ-1:0]     w_grant;
    logic [PTR_W-1:0]       w_idx;
    logic                   w_any;
    logic [FIB_IDX_W-1:0]   w_num;
    logic [PTR_W-1:0]       w_next_ptr;

    fib_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_num      = req_number[FIB_IDX_W*w_idx +: FIB_IDX_W];
    assign w_next_ptr = (r_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

    assign req_ready  = (r_state == ST_IDLE) ? w_grant : '0;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign eng_start  = r_eng_start;
    assign eng_number = r_eng_number;
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_gnt_idx    <= '0;
            r_gnt_oh     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_eng_start  <= 1'b0;
            r_eng_number <= '0;
            r_cnt        <= '0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt_idx <= w_idx;
                        r_gnt_oh  <= w_grant;
                        if (w_num > FIB_IDX_W'(MAX_N)) begin
                            r_state <= ST_RESPOND;
                        end else begin
                            r_eng_number <= w_num;
                            r_eng_start  <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        r_rsp_valid <= r_gnt_oh;
                        r_rsp_data  <= eng_result;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_RESPOND;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_valid <= r_gnt_oh;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_RESPOND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    // Only the out-of-range path arrives without a pulse already
                    // launched; it spends one extra cycle here to raise it.
                    if (r_rsp_valid == '0) begin
                        r_rsp_valid <= r_gnt_oh;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_rsp_valid <= '0;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_request_scheduler.sv
// Scoreboard bench for fib_request_scheduler: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever rsp_valid fires.
module tb_fib_request_scheduler;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;
    localparam int MAX_N   = 30;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_number;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [19:0]          rsp_data;
    logic                 rsp_err;
    logic                 eng_start;
    logic [7:0]           eng_number;
    logic                 eng_done;
    logic [19:0]          eng_result;
    logic                 busy;

    fib_request_scheduler #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .MAX_N   (MAX_N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_number (req_number),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_number (eng_number),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [19:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input logic [19:0] data, input logic err, input int c);
        exp_t e;
        e.id = id; e.data = data; e.err = err; e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clock) begin
        if (!reset && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_valid), 32'(1) << e.id);
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // Engine model: eng_delay cycles after eng_start it pulses done (0 = never)
    int         eng_delay   = 1;
    int         eng_cnt     = 0;
    int         eng_starts  = 0;
    bit         issue_pulse = 1'b0;
    logic [7:0] last_num    = '0;
    logic [7:0] eng_lat     = '0;

    function automatic logic [19:0] fib(input logic [7:0] n);
        logic [31:0] a, b, t;
        a = 0; b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b; a = b; b = t;
        end
        return a[19:0];
    endfunction

    initial begin
        eng_done   = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clock);
            #1;
            eng_done = 1'b0;
            if (eng_start) begin
                eng_starts++;
                last_num   = eng_number;
                eng_lat    = eng_number;
                eng_cnt    = eng_delay;
                eng_result = fib(eng_number);
                eng_done   = issue_pulse;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done   = 1'b1;
                    eng_result = fib(eng_lat);
                end
            end
        end
    end

    task automatic raise(input int id, input logic [7:0] num);
        @(posedge clock);
        #1;
        req_valid[id]          = 1'b1;
        req_number[8*id +: 8]  = num;
    endtask

    task automatic wait_grant(input bit drop, output int gid, output int acc);
        gid = -1;
        acc = -1;
        for (int n = 0; n < 200 && gid < 0; n++) begin
            @(negedge clock);
            if ((req_valid & req_ready) != '0) begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (req_valid[i] && req_ready[i]) gid = i;
                acc = cyc;
            end
        end
        if (gid < 0) begin
            check("grant_timeout", 0, 1);
        end else if (drop) begin
            @(posedge clock);
            #1;
            req_valid[gid] = 1'b0;
        end
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        check("drain", 32'(ok), 1);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    int g, a, a2, s0;
    int rr_id[5]   = '{0, 1, 2, 3, 0};
    int rr_data[5] = '{5, 8, 13, 21, 5};

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_number = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_eng_start", 32'(eng_start), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_eng_number", 32'(eng_number), 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Legal index, engine takes 5 cycles
        eng_delay = 5;
        s0 = eng_starts;
        raise(0, 8'd10);
        wait_grant(1'b1, g, a);
        check("t1_grant", g, 0);
        push(0, 20'd55, 1'b0, a + 7);
        wait_drain();
        check("t1_eng_starts", eng_starts, s0 + 1);
        check("t1_eng_number", 32'(last_num), 10);

        // Out-of-range index: no engine start
        s0 = eng_starts;
        raise(1, 8'd31);
        wait_grant(1'b1, g, a);
        check("t2_grant", g, 1);
        push(1, 20'd0, 1'b1, a + 2);
        wait_drain();
        check("t2_no_eng_start", eng_starts, s0);

        // Largest legal index, minimum latency
        eng_delay = 1;
        raise(1, 8'd30);
        wait_grant(1'b1, g, a);
        push(1, 20'd832040, 1'b0, a + 3);
        wait_drain();

        // Hung engine: timeout error, then next request accepted immediately
        eng_delay = 0;
        raise(2, 8'd7);
        wait_grant(1'b1, g, a);
        push(2, 20'd0, 1'b1, a + TIMEOUT + 2);
        raise(3, 8'd0);
        eng_delay = 1;
        wait_grant(1'b1, g, a2);
        check("t4_next_grant", g, 3);
        check("t4_next_accept_cycle", a2, a + TIMEOUT + 3);
        push(3, 20'd0, 1'b0, a2 + 3);
        wait_drain();

        // eng_done coincides with the timeout cycle: result wins
        eng_delay = TIMEOUT;
        raise(0, 8'd12);
        wait_grant(1'b1, g, a);
        push(0, 20'd144, 1'b0, a + TIMEOUT + 2);
        wait_drain();

        // eng_done only during ISSUE: ignored, timeout reported
        eng_delay   = 0;
        issue_pulse = 1'b1;
        raise(1, 8'd3);
        wait_grant(1'b1, g, a);
        push(1, 20'd0, 1'b1, a + TIMEOUT + 2);
        wait_drain();
        issue_pulse = 1'b0;

        // Round robin with all requesters held valid
        pulse_reset();
        eng_delay = 1;
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_REQ; i++) req_number[8*i +: 8] = 8'(5 + i);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(1'b0, g, a);
            check("rr_order", g, rr_id[k]);
            push(rr_id[k], 20'(rr_data[k]), 1'b0, a + 3);
        end
        @(posedge clock);
        #1 req_valid = '0;
        wait_drain();

        // Reset during WAIT drops the request and restarts the pointer at 0
        eng_delay = 1;
        raise(1, 8'd2);
        wait_grant(1'b1, g, a);
        push(1, 20'd1, 1'b0, a + 3);
        wait_drain();
        eng_delay = 0;
        raise(2, 8'd10);
        wait_grant(1'b1, g, a);
        repeat (3) @(posedge clock);
        pulse_reset();
        @(negedge clock);
        check("rw_busy", 32'(busy), 0);
        check("rw_rsp_valid", 32'(rsp_valid), 0);
        check("rw_rsp_data", 32'(rsp_data), 0);
        check("rw_eng_start", 32'(eng_start), 0);
        check("rw_eng_number", 32'(eng_number), 0);
        eng_delay = 1;
        @(posedge clock);
        #1;
        req_number[7:0]   = 8'd4;
        req_number[31:24] = 8'd9;
        req_valid[0]      = 1'b1;
        req_valid[3]      = 1'b1;
        wait_grant(1'b1, g, a);
        check("rw_first_grant", g, 0);
        push(0, 20'd3, 1'b0, a + 3);
        wait_grant(1'b1, g, a);
        check("rw_second_grant", g, 3);
        push(3, 20'd34, 1'b0, a + 3);
        wait_drain();

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
